// File: rtl/exe_stage.sv
// Execute stage of the five-stage MIPS pipeline: single-cycle ALU, branch target adder,
// and iterative unsigned MUL/DIV that stalls upstream stages until the result is ready.
module exe_stage #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      EXE_CMD,
  input  logic [XLEN-1:0] Val1,
  input  logic [XLEN-1:0] Val2,
  input  logic [XLEN-1:0] Reg2,
  input  logic [XLEN-1:0] PC_in,
  input  logic            Br_taken_in,
  input  logic [4:0]      Dest_in,
  input  logic            MEM_R_EN_in,
  input  logic            MEM_W_EN_in,
  input  logic            WB_EN_in,
  output logic [XLEN-1:0] ALU_Res,
  output logic [XLEN-1:0] Br_addr,
  output logic            Br_taken_out,
  output logic [XLEN-1:0] Reg2_out,
  output logic [4:0]      Dest_out,
  output logic            MEM_R_EN,
  output logic            MEM_W_EN,
  output logic            WB_EN,
  output logic            stall
);

  localparam int CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  localparam logic [3:0] CMD_ADD = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0100;
  localparam logic [3:0] CMD_OR  = 4'b0101;
  localparam logic [3:0] CMD_NOR = 4'b0110;
  localparam logic [3:0] CMD_XOR = 4'b0111;
  localparam logic [3:0] CMD_SLL = 4'b1000;
  localparam logic [3:0] CMD_SRA = 4'b1001;
  localparam logic [3:0] CMD_SRL = 4'b1010;
  localparam logic [3:0] CMD_MUL = 4'b1100;
  localparam logic [3:0] CMD_DIV = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   op_a_q, op_a_d;     // multiplicand / dividend-quotient
  logic [XLEN-1:0]   op_b_q, op_b_d;     // multiplier / divisor
  logic [XLEN-1:0]   acc_q, acc_d;       // product accumulator / remainder
  logic [XLEN-1:0]   result_q, result_d;
  logic              is_div_q, is_div_d;

  logic              is_muldiv_s;
  logic [XLEN-1:0]   alu_s;
  logic [XLEN:0]     rem_sh_s;
  logic [XLEN:0]     rem_sub_s;
  logic [XLEN-1:0]   mul_acc_s;

  assign is_muldiv_s = (EXE_CMD == CMD_MUL) || (EXE_CMD == CMD_DIV);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (is_muldiv_s) begin
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // MUL/DIV datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      is_div_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      is_div_q <= is_div_d;
    end
  end

  // One shift-add or restoring-division step per BUSY cycle; operands latched on entry
  always_comb begin
    cnt_d     = cnt_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    acc_d     = acc_q;
    result_d  = result_q;
    is_div_d  = is_div_q;
    // Remainder is widened by one bit so the shifted value cannot overflow before the compare
    rem_sh_s  = {acc_q, op_a_q[XLEN-1]};
    rem_sub_s = rem_sh_s - {1'b0, op_b_q};
    mul_acc_s = op_b_q[0] ? (acc_q + op_a_q) : acc_q;
    case (state_q)
      IDLE: begin
        if (is_muldiv_s) begin
          op_a_d   = Val1;
          op_b_d   = Val2;
          acc_d    = '0;
          cnt_d    = '0;
          is_div_d = (EXE_CMD == CMD_DIV);
        end else begin
          cnt_d = cnt_q;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (is_div_q) begin
          if (rem_sh_s >= {1'b0, op_b_q}) begin
            acc_d  = rem_sub_s[XLEN-1:0];
            op_a_d = {op_a_q[XLEN-2:0], 1'b1};
          end else begin
            acc_d  = rem_sh_s[XLEN-1:0];
            op_a_d = {op_a_q[XLEN-2:0], 1'b0};
          end
        end else begin
          acc_d  = mul_acc_s;
          op_a_d = {op_a_q[XLEN-2:0], 1'b0};
          op_b_d = {1'b0, op_b_q[XLEN-1:1]};
        end
        if (cnt_q == CNT_LAST) begin
          result_d = is_div_q ? op_a_d : acc_d;
        end else begin
          result_d = result_q;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Single-cycle ALU
  always_comb begin
    alu_s = '0;
    case (EXE_CMD)
      CMD_ADD: alu_s = Val1 + Val2;
      CMD_SUB: alu_s = Val1 - Val2;
      CMD_AND: alu_s = Val1 & Val2;
      CMD_OR:  alu_s = Val1 | Val2;
      CMD_NOR: alu_s = ~(Val1 | Val2);
      CMD_XOR: alu_s = Val1 ^ Val2;
      CMD_SLL: alu_s = Val1 << Val2[4:0];
      CMD_SRA: alu_s = $unsigned($signed(Val1) >>> Val2[4:0]);
      CMD_SRL: alu_s = Val1 >> Val2[4:0];
      default: alu_s = '0;
    endcase
  end

  // FSM outputs: stall is Mealy on EXE_CMD in IDLE and drops while reset is held
  always_comb begin
    stall = 1'b0;
    if (rst) begin
      stall = 1'b0;
    end else if (state_q == BUSY) begin
      stall = 1'b1;
    end else if (state_q == IDLE) begin
      stall = is_muldiv_s;
    end else begin
      stall = 1'b0;
    end

    ALU_Res = '0;
    case (state_q)
      IDLE:    ALU_Res = alu_s;
      DONE:    ALU_Res = result_q;
      default: ALU_Res = '0;
    endcase

    MEM_R_EN = MEM_R_EN_in & ~stall;
    MEM_W_EN = MEM_W_EN_in & ~stall;
    WB_EN    = WB_EN_in & ~stall;
  end

  assign Br_addr      = PC_in + {Val2[XLEN-3:0], 2'b00};
  assign Br_taken_out = Br_taken_in;
  assign Reg2_out     = Reg2;
  assign Dest_out     = Dest_in;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: table of single-cycle ALU vectors plus
// scoreboarded MUL/DIV sequences, reset abort and branch target checks.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  EXE_CMD;
  logic [31:0] Val1, Val2, Reg2, PC_in;
  logic        Br_taken_in;
  logic [4:0]  Dest_in;
  logic        MEM_R_EN_in, MEM_W_EN_in, WB_EN_in;
  logic [31:0] ALU_Res, Br_addr, Reg2_out;
  logic        Br_taken_out;
  logic [4:0]  Dest_out;
  logic        MEM_R_EN, MEM_W_EN, WB_EN, stall;

  always #5 clk = ~clk;

  exe_stage #(.XLEN(32), .ITER(32)) dut (
    .clk(clk), .rst(rst), .EXE_CMD(EXE_CMD), .Val1(Val1), .Val2(Val2), .Reg2(Reg2),
    .PC_in(PC_in), .Br_taken_in(Br_taken_in), .Dest_in(Dest_in),
    .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in), .WB_EN_in(WB_EN_in),
    .ALU_Res(ALU_Res), .Br_addr(Br_addr), .Br_taken_out(Br_taken_out),
    .Reg2_out(Reg2_out), .Dest_out(Dest_out),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN), .stall(stall)
  );

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    EXE_CMD     = cmd;
    Val1        = a;
    Val2        = b;
    Reg2        = a ^ 32'h5A5A_0000;
    Dest_in     = b[4:0] ^ 5'd7;
    WB_EN_in    = 1'b1;
    MEM_R_EN_in = 1'b1;
    MEM_W_EN_in = 1'b1;
  endtask

  function automatic logic [31:0] model(input logic [3:0] cmd, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    case (cmd)
      4'b1100: r = a * b;
      4'b1101: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Drive a MUL/DIV, count stall cycles, then compare the DONE cycle against the scoreboard
  task automatic run_muldiv(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                            input string name, output time t_done);
    int n_stall;
    int bad_ctl;
    logic [31:0] exp;
    @(posedge clk); #1;
    drive(cmd, a, b);
    exp_q.push_back(model(cmd, a, b));
    n_stall = 0;
    bad_ctl = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall) break;
      n_stall++;
      if (WB_EN || MEM_R_EN || MEM_W_EN) bad_ctl++;
    end
    t_done = $time;
    chk({name, " stall_cycles"}, n_stall, 32'd33);
    chk({name, " bubble_ctl"}, bad_ctl, 32'd0);
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      chk({name, " result"}, ALU_Res, exp);
    end else begin
      chk({name, " scoreboard_empty"}, 32'd0, 32'd1);
    end
    chk({name, " done_wb"}, WB_EN, 32'd1);
  endtask

  initial begin
    time t1, t2;
    vecs.push_back('{4'b0000, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001});
    vecs.push_back('{4'b0010, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE});
    vecs.push_back('{4'b0100, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200});
    vecs.push_back('{4'b0101, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01});
    vecs.push_back('{4'b0110, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF});
    vecs.push_back('{4'b0111, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555});
    vecs.push_back('{4'b1000, 32'h0000_0001, 32'h0000_003F, 32'h8000_0000});
    vecs.push_back('{4'b1001, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000});
    vecs.push_back('{4'b1010, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000});
    vecs.push_back('{4'b1001, 32'h4000_0000, 32'h0000_0004, 32'h0400_0000});
    vecs.push_back('{4'b0001, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000});
    vecs.push_back('{4'b1111, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000});

    rst = 1'b1;
    PC_in = 32'd0;
    Br_taken_in = 1'b0;
    drive(4'b0000, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    chk("reset stall", stall, 32'd0);
    chk("reset alu", ALU_Res, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single-cycle ALU table
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      drive(vecs[i].cmd, vecs[i].a, vecs[i].b);
      @(negedge clk);
      chk($sformatf("alu[%0d] res", i), ALU_Res, vecs[i].res);
      chk($sformatf("alu[%0d] stall", i), stall, 32'd0);
      chk($sformatf("alu[%0d] wb", i), WB_EN, 32'd1);
      chk($sformatf("alu[%0d] reg2", i), Reg2_out, vecs[i].a ^ 32'h5A5A_0000);
      chk($sformatf("alu[%0d] dest", i), Dest_out, {27'd0, vecs[i].b[4:0] ^ 5'd7});
    end

    // Branch target
    @(posedge clk); #1;
    drive(4'b0010, 32'd3, 32'hFFFF_FFFE);
    PC_in = 32'h0000_0100;
    Br_taken_in = 1'b1;
    @(negedge clk);
    chk("br addr", Br_addr, 32'h0000_00F8);
    chk("br taken", Br_taken_out, 32'd1);
    chk("br stall", stall, 32'd0);
    Br_taken_in = 1'b0;

    run_muldiv(4'b1100, 32'd7, 32'd6, "mul7x6", t1);
    run_muldiv(4'b1101, 32'd100, 32'd7, "div100/7", t1);
    run_muldiv(4'b1101, 32'd5, 32'd0, "div5/0", t1);
    run_muldiv(4'b1100, 32'h0001_0000, 32'h0001_0000, "mul_trunc", t1);
    run_muldiv(4'b1101, 32'hFFFF_FFFF, 32'h0000_0003, "div_big", t1);
    run_muldiv(4'b1100, 32'hDEAD_BEEF, 32'h0000_1235, "mul_mix", t1);

    // Back-to-back MULs: DONE cycles 34 clocks apart
    run_muldiv(4'b1100, 32'd3, 32'd3, "b2b1", t1);
    run_muldiv(4'b1100, 32'd4, 32'd4, "b2b2", t2);
    chk("b2b spacing", 32'(t2 - t1), 32'd340);

    // Reset at BUSY cycle 10 aborts immediately
    @(posedge clk); #1;
    drive(4'b1100, 32'd9, 32'd9);
    repeat (11) @(negedge clk);
    chk("pre-abort stall", stall, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort stall", stall, 32'd0);
    chk("abort wb", WB_EN, 32'd1);
    drive(4'b0000, 32'd1, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst add", ALU_Res, 32'd2);
    chk("post-rst stall", stall, 32'd0);
    @(negedge clk);
    chk("post-rst stall2", stall, 32'd0);

    chk("scoreboard drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the five-stage MIPS pipeline. It consumes the ID/EXE pipeline register outputs and computes the ALU result and branch target. It also runs unsigned multiply and divide as iterative multi-cycle operations, driving `stall` to freeze PC, IF/ID and ID/EXE until the result is ready. All outputs feed the EXE/MEM pipeline register; `Br_taken_out` and `Br_addr` also go to IF and the flush logic.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported.
- `ITER`, 32, iterations per MUL/DIV; must equal `XLEN`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `EXE_CMD` in 4: operation select.
- `Val1`, `Val2` in 32: operands A and B.
- `Reg2` in 32: store data, passed through.
- `PC_in` in 32: PC+4 of the instruction.
- `Br_taken_in` in 1: branch decision from ID.
- `Dest_in` in 5: destination register.
- `MEM_R_EN_in`, `MEM_W_EN_in`, `WB_EN_in` in 1 each: control bits.
- `ALU_Res` out 32: result.
- `Br_addr` out 32: branch target.
- `Br_taken_out` out 1: branch taken.
- `Reg2_out` out 32, `Dest_out` out 5: pass-through.
- `MEM_R_EN`, `MEM_W_EN`, `WB_EN` out 1 each: gated control bits.
- `stall` out 1: freeze request to the upstream stages.

## Operation
- `EXE_CMD` encoding:
  - 0000 ADD, 0010 SUB, 0100 AND, 0101 OR, 0110 NOR, 0111 XOR.
  - 1000 SLL, 1001 SRA, 1010 SRL; shift amount is `Val2[4:0]`.
  - 1100 MUL: unsigned, low 32 bits of the product.
  - 1101 DIV: unsigned quotient.
  - All other codes give `ALU_Res` = 0.
- ADD and SUB are modulo 2^32; no overflow flag.
- `Br_addr` = `PC_in` + {`Val2[29:0]`,2'b00}, modulo 2^32.
- `Br_taken_out` = `Br_taken_in`. Branches never stall.
- `Reg2_out` and `Dest_out` are always combinational pass-throughs.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - If `EXE_CMD` is not MUL or DIV, the ALU result and control bits pass through combinationally and `stall` = 0.
  - If `EXE_CMD` is MUL or DIV: `stall` = 1 combinationally, the control outputs are forced to 0 (bubble), and the FSM goes to BUSY.
  - At that edge, latch `Val1` and `Val2` into the operand registers, clear the accumulator or remainder, and set the counter to 0.
- BUSY:
  - Perform one iteration per cycle and increment the counter.
  - `stall` = 1 and the control outputs are 0.
  - When counter = `ITER`-1, the next state is DONE.
  - MUL is shift-add: if multiplier bit 0 is 1, add the multiplicand to the accumulator; then shift the multiplicand left and the multiplier right.
  - DIV is restoring: shift {rem, dividend} left by 1; if rem ≥ divisor, subtract and set quotient bit 1.
- DONE:
  - `stall` = 0, `ALU_Res` = latched result, and the control bits pass through from the still-held inputs.
  - The next state is always IDLE. DONE never restarts on the same instruction.
- Divide by zero: quotient = 0xFFFFFFFF. This is the natural restoring result; no special case is needed.
- Upstream holds every input stable while `stall` = 1. The block does not re-sample operands during BUSY.

## Timing
- Reset values: FSM IDLE, counter 0, operand, accumulator and result registers 0, `stall` 0.
- While reset is held, the combinational outputs follow their inputs; the FSM stays in IDLE.
- Reset during BUSY aborts the operation immediately, and `stall` drops in the same cycle.
- Non-MUL/DIV instructions have 0 extra cycles of latency. The result is valid in the cycle the ID/EXE register presents them.
- MUL/DIV: `stall` is high for `ITER`+1 = 33 consecutive cycles (1 IDLE detect cycle + 32 BUSY cycles). The result appears in the 34th cycle (DONE), and the EXE/MEM register captures it at the end of that cycle.
- Back-to-back MUL/DIV: the second instruction enters in IDLE on the cycle after DONE and stalls a full 33 cycles again. There is no dead cycle beyond DONE.
- `stall` is a Mealy output (IDLE & MUL/DIV) | BUSY. It has a combinational path from `EXE_CMD`.

## Test plan
- ADD 0xFFFFFFFF + 0x00000002 → `ALU_Res` = 0x00000001 in the same cycle; `stall` stays 0 throughout.
- SRA 0x80000000 by 4 → 0xF8000000; SRL of the same value → 0x08000000; NOR 0,0 → 0xFFFFFFFF.
- MUL 7 × 6 with `WB_EN_in` = 1 → `stall` high for exactly 33 cycles with `WB_EN` = 0; then one DONE cycle with `ALU_Res` = 42 and `WB_EN` = 1.
- DIV 100 / 7 → 14 after 33 stall cycles. DIV 5 / 0 → 0xFFFFFFFF. MUL 0x10000 × 0x10000 → 0x00000000 (truncated).
- Assert `rst` at BUSY cycle 10 of a MUL → `stall` = 0 immediately. After release, an ADD 1 + 1 gives 2 with no stall.
- BEQ with `PC_in` = 0x100, `Val2` = 0xFFFFFFFE, `Br_taken_in` = 1 → `Br_addr` = 0x000000F8 and `Br_taken_out` = 1, with no stall.
- Two consecutive MULs (3×3, then 4×4) → results 9 and 16, 34 cycles apart.
